// File: rtl/adder_sum_accumulator.sv
// Accumulates 5-bit adder results {cout, s} over a programmable number of beats
// and hands the wide total plus a sticky overflow flag to a downstream consumer.
module adder_sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic             cout,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1'b1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [CNT_W:0]   cnt_r, cnt_s;
  logic [CNT_W:0]   len_r, len_s;
  logic             ovf_r, ovf_s;

  logic [ACC_W-1:0] beat_s;
  logic [ACC_W:0]   sum_s;
  logic [CNT_W:0]   len_eff_s;
  logic             accept_s;
  logic             deliver_s;

  // Handshake strobes come from the registered state; clear blocks both transfers.
  assign in_ready  = (state_r != DONE) && !clear;
  assign out_valid = (state_r == DONE) && !clear;
  assign busy      = (state_r != IDLE);
  assign out_sum   = acc_r;
  assign out_ovf   = ovf_r;

  assign accept_s  = in_valid && in_ready;
  assign deliver_s = out_valid && out_ready;
  assign beat_s    = ACC_W'({cout, s});
  assign sum_s     = {1'b0, acc_r} + {1'b0, beat_s};
  assign len_eff_s = (len == {CNT_W{1'b0}}) ? CNT_MAX : {1'b0, len};

  // Next-state and datapath update.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    len_s   = len_r;
    ovf_s   = ovf_r;
    if (clear) begin
      state_s = IDLE;
      acc_s   = {ACC_W{1'b0}};
      cnt_s   = {(CNT_W+1){1'b0}};
      len_s   = {(CNT_W+1){1'b0}};
      ovf_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            len_s   = len_eff_s;
            acc_s   = beat_s;
            ovf_s   = 1'b0;
            cnt_s   = CNT_ONE;
            state_s = (len_eff_s == CNT_ONE) ? DONE : ACC;
          end else begin
            state_s = IDLE;
          end
        end
        ACC: begin
          if (accept_s) begin
            acc_s   = sum_s[ACC_W-1:0];
            ovf_s   = ovf_r | sum_s[ACC_W];
            cnt_s   = cnt_r + CNT_ONE;
            state_s = ((cnt_r + CNT_ONE) == len_r) ? DONE : ACC;
          end else begin
            state_s = ACC;
          end
        end
        DONE: begin
          if (deliver_s) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {(CNT_W+1){1'b0}};
      len_r   <= {(CNT_W+1){1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      ovf_r   <= ovf_s;
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: stimulus pushes expected results,
// a monitor pops and compares them on every output handshake.
module tb_adder_sum_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] s;
  logic       cout;
  logic [3:0] len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  adder_sum_accumulator #(.ACC_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .cout(cout), .len(len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got sum 0x%0h ovf %0b, expected none", out_sum, out_ovf);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("result_sum", {24'd0, out_sum}, {24'd0, e[7:0]});
        check("result_ovf", {31'd0, out_ovf}, {31'd0, e[8]});
      end
    end
  end

  task automatic beat(input logic [3:0] sv, input logic cv, input logic [3:0] lv);
    in_valid = 1'b1;
    s        = sv;
    cout     = cv;
    len      = lv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 60) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; s = 4'd0; cout = 1'b0;
    len = 4'd0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   {24'd0, out_sum},   32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic run: 5 + 31 + 2 = 38
    exp_q.push_back({1'b0, 8'd38});
    beat(4'd5, 1'b0, 4'd3);
    check("basic_busy_mid", {31'd0, busy}, 32'd1);
    beat(4'd15, 1'b1, 4'd3);
    beat(4'd2, 1'b0, 4'd3);
    check("basic_out_valid", {31'd0, out_valid}, 32'd1);
    check("basic_busy_done", {31'd0, busy}, 32'd1);
    check("basic_in_ready_done", {31'd0, in_ready}, 32'd0);
    bubble();
    check("basic_idle_busy", {31'd0, busy}, 32'd0);
    check("basic_idle_valid", {31'd0, out_valid}, 32'd0);
    check("basic_idle_sum_held", {24'd0, out_sum}, 32'd38);

    // Wrap run: 16 x 31 = 496 -> 0xF0 with overflow
    exp_q.push_back({1'b1, 8'hF0});
    for (int i = 0; i < 16; i++) begin
      beat(4'd15, 1'b1, 4'd0);
      if (i == 7) check("wrap_ovf_clear_at_248", {31'd0, out_ovf}, 32'd0);
      if (i == 8) check("wrap_ovf_set_at_279", {31'd0, out_ovf}, 32'd1);
    end
    check("wrap_out_valid", {31'd0, out_valid}, 32'd1);
    wait_idle("wrap_idle");

    // Backpressure: 7 + 8 = 15, result held while out_ready is low
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'd15});
    beat(4'd7, 1'b0, 4'd2);
    beat(4'd8, 1'b0, 4'd2);
    in_valid = 1'b1;
    s = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_sum", {24'd0, out_sum}, 32'd15);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    bubble();
    check("bp_idle_busy", {31'd0, busy}, 32'd0);
    check("bp_idle_sum", {24'd0, out_sum}, 32'd15);

    // Bubbles: 1+2+3+4 = 10, then a single-beat run of 9
    exp_q.push_back({1'b0, 8'd10});
    beat(4'd1, 1'b0, 4'd4);
    bubble();
    beat(4'd2, 1'b0, 4'd4);
    bubble();
    beat(4'd3, 1'b0, 4'd4);
    check("bubble_not_done", {31'd0, out_valid}, 32'd0);
    bubble();
    beat(4'd4, 1'b0, 4'd4);
    check("bubble_out_valid", {31'd0, out_valid}, 32'd1);
    wait_idle("bubble_idle");
    exp_q.push_back({1'b0, 8'd9});
    beat(4'd9, 1'b0, 4'd1);
    check("single_out_valid", {31'd0, out_valid}, 32'd1);
    check("single_out_sum", {24'd0, out_sum}, 32'd9);
    wait_idle("single_idle");

    // Abort after 2 of 5 beats, then a 3 + 4 run
    beat(4'd1, 1'b0, 4'd5);
    beat(4'd2, 1'b0, 4'd5);
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_sum", {24'd0, out_sum}, 32'd0);
    exp_q.push_back({1'b0, 8'd7});
    beat(4'd3, 1'b0, 4'd2);
    beat(4'd4, 1'b0, 4'd2);
    wait_idle("after_clear_idle");

    // Asynchronous reset mid-run, then 10 + 20 = 30
    beat(4'd3, 1'b0, 4'd5);
    beat(4'd3, 1'b0, 4'd5);
    beat(4'd3, 1'b0, 4'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_sum", {24'd0, out_sum}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 8'd30});
    beat(4'd10, 1'b0, 4'd2);
    beat(4'd4, 1'b1, 4'd2);
    wait_idle("after_rst_idle");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
